d_flipflop_a: RTL and testbench

Parameterizable, rising-edge D-type register stage with synchronous reset, used as the basic storage/retiming cell in datapath and control logic. With default parameters it is a single 1-bit D flip-flop: `q` takes the value of `d` sampled at each rising clock edge. Optional parameters widen the data path, chain several register stages for extra latency, and set the reset value.

---
 rtl/d_flipflop_a.sv | 32 +++
 tb/tb_d_flipflop_a.sv | 139 +++++++++++++
 2 files changed

// File: rtl/d_flipflop_a.sv
// Parameterizable D-type register chain: DEPTH cascaded WIDTH-bit stages, rising-edge clocked.
// The rst_n port is active-high and synchronous; it loads RST_VAL into every stage.
module d_flipflop_a #(
  parameter int unsigned             WIDTH   = 1,
  parameter int unsigned             DEPTH   = 1,
  parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Reset wins over data and flushes every in-flight stage in the same edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage[i] <= RST_VAL;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: tb/tb_d_flipflop_a.sv
// Bench for d_flipflop_a: a default 1-bit single-stage instance and an 8-bit, 3-deep instance
// with reset value 8'hA5, both checked through latency-ordered expectation queues.
module tb_d_flipflop_a;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       d_a;
  logic       q_a;
  logic       rst_b;
  logic [7:0] d_b;
  logic [7:0] q_b;

  int checks = 0;
  int errors = 0;

  logic       sb_a [$];
  logic [7:0] sb_b [$];

  always #2 clk = ~clk;

  d_flipflop_a u_dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .d     (d_a),
    .q     (q_a)
  );

  d_flipflop_a #(
    .WIDTH   (8),
    .DEPTH   (3),
    .RST_VAL (8'hA5)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .d     (d_b),
    .q     (q_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called 1 time unit before an edge: drive, let the edge pass, check just after it
  // and again just before the following edge (output must hold in between).
  task automatic step_a(input logic r, input logic dv, input string tag);
    logic e;
    rst_a = r;
    d_a   = dv;
    sb_a.push_back(r ? 1'b0 : dv);
    @(posedge clk);
    #1;
    e = sb_a.pop_front();
    check(tag, 32'(q_a), 32'(e));
    #2;
    check({tag, "_hold"}, 32'(q_a), 32'(e));
  endtask

  // Reset refills the queue with RST_VAL for this edge plus the DEPTH-1 release edges.
  task automatic step_b(input logic r, input logic [7:0] dv, input string tag);
    logic [7:0] e;
    rst_b = r;
    d_b   = dv;
    if (r) begin
      sb_b.delete();
      repeat (3) sb_b.push_back(8'hA5);
    end else begin
      sb_b.push_back(dv);
    end
    @(posedge clk);
    #1;
    e = sb_b.pop_front();
    check(tag, 32'(q_b), 32'(e));
    #2;
    check({tag, "_hold"}, 32'(q_b), 32'(e));
  endtask

  initial begin
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_a = 1'b1;
    d_a   = 1'b1;
    rst_b = 1'b1;
    d_b   = 8'h00;

    // Reset with d=1 held for two edges
    step_a(1'b1, 1'b1, "a_rst0");
    step_a(1'b1, 1'b1, "a_rst1");

    // Data capture
    foreach (pat[i]) step_a(1'b0, pat[i], $sformatf("a_data%0d", i));

    // Mid-operation reset and release (q is 1 here)
    step_a(1'b1, 1'b1, "a_midrst");
    step_a(1'b0, 1'b1, "a_release");

    // Reset pulse wholly between edges is ignored
    @(posedge clk);
    #1 rst_a = 1'b1;
    #1 rst_a = 1'b0;
    #1;
    check("a_pulse_mid", 32'(q_a), 32'd1);
    step_a(1'b0, 1'b1, "a_pulse_edge");

    // Mid-cycle glitches on d: only the edge value is captured
    step_a(1'b0, 1'b0, "a_pre_glitch");
    @(posedge clk);
    #1 d_a = 1'b1;
    #1 d_a = 1'b0;
    #1;
    check("a_glitch_mid", 32'(q_a), 32'd0);
    d_a = 1'b1;
    @(posedge clk);
    #1;
    check("a_glitch_edge1", 32'(q_a), 32'd1);
    #1 d_a = 1'b0;
    #1 d_a = 1'b1;
    #1;
    check("a_glitch_mid2", 32'(q_a), 32'd1);
    d_a = 1'b0;
    @(posedge clk);
    #1;
    check("a_glitch_edge0", 32'(q_a), 32'd0);
    #2;

    // Wide, deep instance: reset, fill, mid-flight reset, refill
    step_b(1'b1, 8'hFF, "b_rst0");
    step_b(1'b1, 8'h33, "b_rst1");
    for (int i = 1; i <= 7; i++) step_b(1'b0, 8'(i), $sformatf("b_data%0d", i));
    step_b(1'b1, 8'h08, "b_midrst");
    for (int i = 9; i <= 12; i++) step_b(1'b0, 8'(i), $sformatf("b_refill%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
